// File: rtl/cache_line_arbiter.sv
// -----------------------------------------------------------------------------
// cache_line_arbiter
//
// Purpose:
//   Shares one line-granular cache port (the upstream side of the L2
//   cache_core) between the I-cache and D-cache miss ports. Only one
//   transaction is in flight at a time. The winning requester's
//   op/address/wdata are captured on the grant edge and held on the
//   downstream side until downstream_resp. The response is then routed back
//   to that requester only.
//
// Configuration macro:
//   CACHE_ARB_RR_EN  undefined -> fixed priority, D-side wins a tie.
//                    defined   -> round-robin. On a tie, the side that was
//                                 not granted last wins. last_grant resets
//                                 to I, so the first tie after reset goes
//                                 to D.
//
// Parameters:
//   s_line  line width in bits
//   s_addr  address width in bits
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   i_read/i_write           I-side request, held high until i_resp
//   i_address, i_wdata       I-side line address / write line
//   i_rdata, i_resp          I-side read line (0 unless i_resp) / completion
//   d_read/d_write           D-side request, held high until d_resp
//   d_address, d_wdata       D-side line address / write line
//   d_rdata, d_resp          D-side read line (0 unless d_resp) / completion
//   downstream_read/write    request to L2 (registered)
//   downstream_address/wdata latched address / write line to L2
//   downstream_rdata/resp    read line / completion from L2
// -----------------------------------------------------------------------------
module cache_line_arbiter #(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [s_addr-1:0] i_address,
    input  logic [s_line-1:0] i_wdata,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_addr-1:0] d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,

    output logic              downstream_read,
    output logic              downstream_write,
    output logic [s_addr-1:0] downstream_address,
    output logic [s_line-1:0] downstream_wdata,
    input  logic [s_line-1:0] downstream_rdata,
    input  logic              downstream_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state;
    logic              op_read;
    logic              op_write;
    logic [s_addr-1:0] addr_q;
    logic [s_line-1:0] wdata_q;

    logic              i_req;
    logic              d_req;
    logic              grant_i;
    logic              grant_d;

    // A requester asserting read and write together is served as a write.
    // Result is {op_read, op_write}.
    function automatic logic [1:0] decode_op(input logic rd, input logic wr);
        return {rd & ~wr, wr};
    endfunction

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

`ifdef CACHE_ARB_RR_EN
    // 1 = D was granted last, 0 = I was granted last.
    logic last_grant_d;

    // On a tie, the side that was not granted last wins.
    // A lone requester always wins.
    assign grant_d = d_req & (~i_req | ~last_grant_d);
`else
    // Fixed priority: D always wins a tie. I can starve under continuous D traffic.
    assign grant_d = d_req;
`endif
    assign grant_i = i_req & ~grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_read  <= 1'b0;
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef CACHE_ARB_RR_EN
            last_grant_d <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state                 <= SERVE_D;
                        {op_read, op_write}   <= decode_op(d_read, d_write);
                        addr_q                <= d_address;
                        wdata_q               <= d_wdata;
`ifdef CACHE_ARB_RR_EN
                        last_grant_d          <= 1'b1;
`endif
                    end else if (grant_i) begin
                        state                 <= SERVE_I;
                        {op_read, op_write}   <= decode_op(i_read, i_write);
                        addr_q                <= i_address;
                        wdata_q               <= i_wdata;
`ifdef CACHE_ARB_RR_EN
                        last_grant_d          <= 1'b0;
`endif
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Dropping the op registers here gives the guaranteed
                    // idle cycle on the downstream port after every resp.
                    if (downstream_resp) begin
                        state    <= IDLE;
                        op_read  <= 1'b0;
                        op_write <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    op_read  <= 1'b0;
                    op_write <= 1'b0;
                end
            endcase
        end
    end

    // Downstream side is driven purely from the latched registers, so
    // requester changes during a transaction have no effect.
    assign downstream_read    = op_read;
    assign downstream_write   = op_write;
    assign downstream_address = addr_q;
    assign downstream_wdata   = wdata_q;

    // Completion is forwarded combinationally, to the served side only.
    // A resp seen in IDLE is dropped.
    assign i_resp  = downstream_resp & (state == SERVE_I);
    assign d_resp  = downstream_resp & (state == SERVE_D);
    assign i_rdata = i_resp ? downstream_rdata : '0;
    assign d_rdata = d_resp ? downstream_rdata : '0;

endmodule

// File: tb/tb_cache_line_arbiter.sv
module tb_cache_line_arbiter;
    localparam int S_LINE = 256;
    localparam int S_ADDR = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read, i_write, d_read, d_write;
    logic [S_ADDR-1:0] i_address, d_address;
    logic [S_LINE-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
    logic              i_resp, d_resp;
    logic              downstream_read, downstream_write, downstream_resp;
    logic [S_ADDR-1:0] downstream_address;
    logic [S_LINE-1:0] downstream_wdata, downstream_rdata;

    always #5 clk = ~clk;

    cache_line_arbiter #(.s_line(S_LINE), .s_addr(S_ADDR)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .downstream_read(downstream_read), .downstream_write(downstream_write),
        .downstream_address(downstream_address), .downstream_wdata(downstream_wdata),
        .downstream_rdata(downstream_rdata), .downstream_resp(downstream_resp)
    );

    int total  = 0;
    int passed = 0;

    // Scoreboard: expected grant order (1 = D, 0 = I) and per-side read lines.
    bit                exp_side_q[$];
    logic [S_LINE-1:0] exp_i_q[$];
    logic [S_LINE-1:0] exp_d_q[$];

    // L2 responder controls.
    bit                l2_en;
    int                l2_lat;
    int                l2_cnt;
    bit                l2_fixed;
    logic [S_LINE-1:0] l2_data;
    bit                spur;

    function automatic logic [S_LINE-1:0] line_of(input logic [S_ADDR-1:0] a);
        return {8{a}};
    endfunction

    task automatic chk(input string name, input logic [S_LINE-1:0] act, input logic [S_LINE-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // L2 model: answers after l2_lat cycles of a held request; data is the
    // address replicated across the line unless a fixed pattern is selected.
    initial begin
        downstream_resp  = 1'b0;
        downstream_rdata = '0;
        l2_cnt           = 0;
        forever begin
            @(posedge clk); #1;
            if (downstream_resp) begin
                downstream_resp  = 1'b0;
                downstream_rdata = '0;
                l2_cnt           = 0;
            end else if (spur) begin
                downstream_resp  = 1'b1;
                downstream_rdata = {32{8'h3C}};
            end else if (l2_en && (downstream_read || downstream_write)) begin
                if (l2_cnt >= l2_lat) begin
                    downstream_resp  = 1'b1;
                    downstream_rdata = l2_fixed ? l2_data : line_of(downstream_address);
                end else begin
                    l2_cnt++;
                end
            end else begin
                l2_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a requester sees a completion.
    initial begin
        bit               prev_resp;
        bit               s;
        logic [S_LINE-1:0] e;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_resp) chk("dead_cycle", {downstream_read, downstream_write}, 0);
            prev_resp = 1'b0;
            if (i_resp || d_resp) begin
                prev_resp = 1'b1;
                chk("one_resp_only", i_resp & d_resp, 0);
                if (exp_side_q.size() == 0) begin
                    chk("stray_resp", {i_resp, d_resp}, 0);
                end else begin
                    s = exp_side_q.pop_front();
                    chk("grant_order_d_resp", d_resp, s);
                    if (d_resp) begin
                        e = (exp_d_q.size() != 0) ? exp_d_q.pop_front() : '1;
                        chk("d_rdata", d_rdata, e);
                        chk("i_rdata_quiet", i_rdata, 0);
                    end else begin
                        e = (exp_i_q.size() != 0) ? exp_i_q.pop_front() : '1;
                        chk("i_rdata", i_rdata, e);
                        chk("d_rdata_quiet", d_rdata, 0);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit side, input bit rd, input bit wr,
                           input logic [S_ADDR-1:0] a, input logic [S_LINE-1:0] wd);
        if (side) begin
            d_read = rd; d_write = wr; d_address = a; d_wdata = wd;
        end else begin
            i_read = rd; i_write = wr; i_address = a; i_wdata = wd;
        end
    endtask

    // Waits (bounded) for the side's resp, then returns at posedge+1 of the
    // following IDLE cycle.
    task automatic wait_resp(input bit side);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(side ? d_resp : i_resp) && n < 300);
        if (!(side ? d_resp : i_resp)) chk(side ? "d_resp_timeout" : "i_resp_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic txn(input bit side, input logic [S_ADDR-1:0] a, input bit keep);
        if (side) exp_d_q.push_back(line_of(a));
        else      exp_i_q.push_back(line_of(a));
        set_req(side, 1'b1, 1'b0, a, '0);
        wait_resp(side);
        if (!keep) set_req(side, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0; l2_en = 1'b1; l2_lat = 2; l2_fixed = 1'b0; l2_data = '0; spur = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_5000, '0);
        set_req(1'b1, 1'b1, 1'b0, 32'h0000_6000, '0);

        // Reset with both sides requesting: everything quiet.
        repeat (2) @(negedge clk);
        chk("rst_dread",  downstream_read, 0);
        chk("rst_dwrite", downstream_write, 0);
        chk("rst_daddr",  downstream_address, 0);
        chk("rst_dwdata", downstream_wdata, 0);
        chk("rst_resps",  {i_resp, d_resp}, 0);
        chk("rst_rdatas", i_rdata | d_rdata, 0);

        // Tie right after reset: D first, then I.
        exp_side_q.push_back(1'b1); exp_d_q.push_back(line_of(32'h0000_6000));
        exp_side_q.push_back(1'b0); exp_i_q.push_back(line_of(32'h0000_5000));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_dread", downstream_read, 0);
        @(negedge clk);
        chk("post_rst_grant_dread", downstream_read, 1);
        chk("post_rst_grant_addr", downstream_address, 32'h0000_6000);
        fork
            begin wait_resp(1'b1); set_req(1'b1, 1'b0, 1'b0, '0, '0); end
            begin wait_resp(1'b0); set_req(1'b0, 1'b0, 1'b0, '0, '0); end
        join
        idle(2);

        // Lone I read with a fixed A5 line from L2.
        l2_fixed = 1'b1; l2_data = {32{8'hA5}};
        exp_side_q.push_back(1'b0); exp_i_q.push_back({32{8'hA5}});
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_1000, '0);
        @(negedge clk);
        chk("lone_i_req_cycle_dread", downstream_read, 0);
        @(negedge clk);
        chk("lone_i_dread", downstream_read, 1);
        chk("lone_i_addr", downstream_address, 32'h0000_1000);
        chk("lone_i_rdata_zero_no_resp", i_rdata, 0);
        wait_resp(1'b0);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        l2_fixed = 1'b0;
        idle(2);

        // D write: latched values hold while the requester changes its inputs.
        l2_lat = 4;
        exp_side_q.push_back(1'b1); exp_d_q.push_back(line_of(32'h0000_2040));
        set_req(1'b1, 1'b0, 1'b1, 32'h0000_2040, 256'h1234);
        repeat (2) @(negedge clk);
        chk("latch_dwrite", downstream_write, 1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b0, 32'hFFFF_FFC0, '1);
        repeat (2) begin
            @(negedge clk);
            chk("latch_addr", downstream_address, 32'h0000_2040);
            chk("latch_wdata", downstream_wdata, 256'h1234);
            chk("latch_ops", {downstream_read, downstream_write}, 2'b01);
        end
        wait_resp(1'b1);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        l2_lat = 2;
        idle(2);

        // Read and write together is served as a write.
        exp_side_q.push_back(1'b0); exp_i_q.push_back(line_of(32'h0000_7000));
        set_req(1'b0, 1'b1, 1'b1, 32'h0000_7000, 256'hBEEF);
        repeat (2) @(negedge clk);
        chk("rw_both_ops", {downstream_read, downstream_write}, 2'b01);
        chk("rw_both_wdata", downstream_wdata, 256'hBEEF);
        wait_resp(1'b0);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        idle(2);

        // Resp arriving in IDLE is not forwarded.
        @(negedge clk); spur = 1'b1;
        @(negedge clk); spur = 1'b0;
        chk("idle_resp_ignored", {i_resp, d_resp}, 0);
        chk("idle_resp_rdata", i_rdata | d_rdata, 0);
        idle(2);

        // I drops its request mid-transaction: latched op still completes.
        exp_side_q.push_back(1'b0); exp_i_q.push_back(line_of(32'h0000_8000));
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_8000, '0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        wait_resp(1'b0);
        idle(2);

        // Reset in the middle of SERVE_I.
        l2_en = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_9000, '0);
        repeat (2) @(negedge clk);
        chk("midop_dread_before", downstream_read, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midop_dread_immediate", downstream_read, 0);
        chk("midop_addr_cleared", downstream_address, 0);
        @(negedge clk);
        chk("midop_in_reset_resps", {i_resp, d_resp, downstream_write}, 0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1; l2_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midop_after_release_idle", {downstream_read, downstream_write, i_resp, d_resp}, 0);
        end

        // Reset so last_grant is I, then both sides hold two requests each.
        @(posedge clk); #1; rst_n = 1'b0;
        idle(2); rst_n = 1'b1;
`ifdef CACHE_ARB_RR_EN
        exp_side_q.push_back(1'b1); exp_side_q.push_back(1'b0);
        exp_side_q.push_back(1'b1); exp_side_q.push_back(1'b0);
`else
        exp_side_q.push_back(1'b1); exp_side_q.push_back(1'b1);
        exp_side_q.push_back(1'b0); exp_side_q.push_back(1'b0);
`endif
        fork
            begin txn(1'b1, 32'h0000_3000, 1'b1); txn(1'b1, 32'h0000_3040, 1'b0); end
            begin txn(1'b0, 32'h0000_4000, 1'b1); txn(1'b0, 32'h0000_4040, 1'b0); end
        join
        idle(3);

        chk("sb_order_empty", exp_side_q.size(), 0);
        chk("sb_i_empty", exp_i_q.size(), 0);
        chk("sb_d_empty", exp_d_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
